pc_control_unit: RTL and testbench
==================================

// Module: pc_control_unit
// PURPOSE
//  Parametrised next-generation PC unit for the single-cycle core: holds the PC, resolves all six
//  RISC-V conditional branches from ALU flags plus JAL/JALR, and supports a pipeline-freeze stall.
//  Detects misaligned control-flow targets and vectors to a trap handler, with EPC capture and
//  trap return. A double fault halts the core. Also counts retired instructions.
// PARAMETERS
//  XLEN        64     PC/data width in bits
//  RESET_PC    0      PC value loaded on reset
//  TRAP_VEC    'h200  PC loaded on misaligned-target trap (must be 4-byte aligned)
//  ALIGN_CHECK 1      1: check target[1:0]!=0 on a taken redirect; 0: no check, never traps
//  CNT_W       32     width of the retired-instruction counter
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     asynchronous, active-high reset
//  stall      in   1     1: freeze all state this cycle; all control inputs ignored
//  Branch     in   1     conditional branch instruction
//  Jump       in   1     JAL: target = PC_out + immediate
//  JumpReg    in   1     JALR: target = (rs1_data + immediate) & ~1
//  funct3     in   3     branch condition select
//  Zero       in   1     ALU result == 0
//  LessThan   in   1     signed rs1 < rs2
//  LessThanU  in   1     unsigned rs1 < rs2
//  immediate  in   XLEN  sign-extended, pre-shifted byte offset
//  rs1_data   in   XLEN  JALR base register value
//  trap_ret   in   1     return from trap handler (honoured only in TRAP)
//  PC_out     out  XLEN  current PC (registered)
//  link_addr  out  XLEN  PC_out + 4 (comb), the rd value for JAL/JALR
//  take_branch out 1     comb: a redirect is selected this cycle (before the alignment check)
//  EPC        out  XLEN  PC of the faulting instruction (registered)
//  in_trap    out  1     state == TRAP
//  halted     out  1     state == HALT
//  instret    out  CNT_W retired-instruction count
// BEHAVIOUR
//  Reset (async): PC_out=RESET_PC, EPC=0, state=RUN, instret=0; held while reset=1.
//  Branch condition: 000 BEQ Zero; 001 BNE !Zero; 100 BLT LessThan; 101 BGE !LessThan;
//   110 BLTU LessThanU; 111 BGEU !LessThanU; 010/011 never taken.
//  Priority: JumpReg > Jump > (Branch & cond) > sequential PC_out+4.
//  All additions are modulo 2^XLEN; wrap-around is legal and raises no error.
//  A redirect target is misaligned when ALIGN_CHECK=1 and target[1:0]!=0; PC+4 is never checked.
//  FSM (update on posedge clk, only when stall=0):
//   RUN : misaligned target -> PC<=TRAP_VEC, EPC<=PC_out, go TRAP; otherwise PC<=next;
//         trap_ret is ignored (treated as a normal sequential step).
//   TRAP: trap_ret=1 -> PC<=EPC+4, go RUN (trap_ret has priority over any jump/branch);
//         misaligned target -> double fault: go HALT, PC and EPC unchanged;
//         otherwise PC<=next, stay TRAP.
//   HALT: PC, EPC and instret frozen; only reset exits.
//  instret += 1 on every non-stalled cycle in RUN or TRAP, including the trapping cycle; wraps at 2^CNT_W.
//  stall=1: no state changes; combinational outputs still track the inputs.
//  Reset asserted mid-operation (any state) forces the reset values immediately.
// TESTING (XLEN=64, RESET_PC=0, TRAP_VEC='h200)
//  1 Reset, then 3 clean cycles -> PC_out=12, instret=3, link_addr=16.
//  2 PC=12, Branch=1, funct3=001, Zero=0, imm=32 -> PC=44; next cycle funct3=110, LessThanU=0 -> PC=48.
//  3 JumpReg=1, rs1_data='h101, imm=4 -> PC='h104; then stall=1 for 2 cycles with Jump=1 -> PC stays 'h104, instret unchanged.
//  4 PC='h104, Jump=1, imm=6 -> PC='h200, EPC='h104, in_trap=1; 2 cycles later trap_ret=1 -> PC='h108, in_trap=0.
//  5 In TRAP, Jump=1, imm=2 -> halted=1, PC frozen across 5 cycles; then reset=1 -> PC=0, halted=0.
//  6 PC=0, Branch=1, funct3=000, Zero=1, imm=-4 -> PC='hFFFF_FFFF_FFFF_FFFC, no trap; funct3=010 -> never taken.

Source files
------------

// File: rtl/pc_control_unit.sv
// PC unit for the single-cycle core: next-PC selection for branches/JAL/JALR,
// pipeline freeze, misaligned-target trap with EPC capture and trap return,
// double-fault halt, and a retired-instruction counter.
module pc_control_unit #(
  parameter int unsigned XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h200),
  parameter int unsigned ALIGN_CHECK = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             JumpReg,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             LessThan,
  input  logic             LessThanU,
  input  logic [XLEN-1:0]  immediate,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic             trap_ret,
  output logic [XLEN-1:0]  PC_out,
  output logic [XLEN-1:0]  link_addr,
  output logic             take_branch,
  output logic [XLEN-1:0]  EPC,
  output logic             in_trap,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_TRAP = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [CNT_W-1:0] r_instret;

  logic            w_cond;
  logic [XLEN-1:0] w_pc_rel_tgt;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_redirect;
  logic            w_misaligned;

  // Branch condition decode from ALU flags; 010/011 are never taken.
  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      3'b000:  w_cond = Zero;
      3'b001:  w_cond = ~Zero;
      3'b100:  w_cond = LessThan;
      3'b101:  w_cond = ~LessThan;
      3'b110:  w_cond = LessThanU;
      3'b111:  w_cond = ~LessThanU;
      default: w_cond = 1'b0;
    endcase
  end

  // Target selection: JALR > JAL > taken branch > sequential; all adds wrap.
  always_comb begin
    w_pc_rel_tgt = r_pc + immediate;
    w_jalr_tgt   = (rs1_data + immediate) & ~XLEN'(1);
    w_redirect   = JumpReg | Jump | (Branch & w_cond);
    w_target     = JumpReg ? w_jalr_tgt : w_pc_rel_tgt;
    w_next_pc    = w_redirect ? w_target : link_addr;
    w_misaligned = (ALIGN_CHECK != 0) && w_redirect && (w_target[1:0] != 2'b00);
  end

  // Control FSM with PC, EPC and retired-count updates; stall freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_epc     <= '0;
      r_instret <= '0;
    end else if (!stall) begin
      case (r_state)
        S_RUN: begin
          r_instret <= r_instret + CNT_W'(1);
          if (w_misaligned) begin
            r_pc    <= TRAP_VEC;
            r_epc   <= r_pc;
            r_state <= S_TRAP;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        S_TRAP: begin
          r_instret <= r_instret + CNT_W'(1);
          if (trap_ret) begin
            r_pc    <= r_epc + XLEN'(4);
            r_state <= S_RUN;
          end else if (w_misaligned) begin
            // Double fault: PC and EPC keep the state that led here.
            r_state <= S_HALT;
          end else begin
            r_pc <= w_next_pc;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign link_addr   = r_pc + XLEN'(4);
  assign take_branch = w_redirect;
  assign PC_out      = r_pc;
  assign EPC         = r_epc;
  assign in_trap     = (r_state == S_TRAP);
  assign halted      = (r_state == S_HALT);
  assign instret     = r_instret;

endmodule

// File: tb/tb_pc_control_unit.sv
// Scoreboard bench for pc_control_unit: stimulus pushes hand-computed expected
// state per cycle, a negedge monitor pops and compares.
module tb_pc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        Branch, Jump, JumpReg;
  logic [2:0]  funct3;
  logic        Zero, LessThan, LessThanU;
  logic [63:0] immediate, rs1_data;
  logic        trap_ret;
  logic [63:0] PC_out, link_addr, EPC;
  logic        take_branch, in_trap, halted;
  logic [31:0] instret;

  int n_tot  = 0;
  int n_pass = 0;

  typedef struct {
    int          id;
    logic [63:0] pc;
    logic [63:0] epc;
    logic        trap;
    logic        halt;
    logic        tb;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_control_unit #(
    .XLEN(64), .RESET_PC(64'h0), .TRAP_VEC(64'h200), .ALIGN_CHECK(1), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .funct3(funct3),
    .Zero(Zero), .LessThan(LessThan), .LessThanU(LessThanU),
    .immediate(immediate), .rs1_data(rs1_data), .trap_ret(trap_ret),
    .PC_out(PC_out), .link_addr(link_addr), .take_branch(take_branch),
    .EPC(EPC), .in_trap(in_trap), .halted(halted), .instret(instret)
  );

  task automatic chk(input int id, input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tot++;
    if (got !== want)
      $display("FAIL step%0d %s: got %h required %h", id, nm, got, want);
    else
      n_pass++;
  endtask

  // Monitor: compare DUT outputs against the oldest expected record.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "PC_out",      PC_out,            e.pc);
      chk(e.id, "link_addr",   link_addr,         e.pc + 64'd4);
      chk(e.id, "EPC",         EPC,               e.epc);
      chk(e.id, "in_trap",     64'(in_trap),      64'(e.trap));
      chk(e.id, "halted",      64'(halted),       64'(e.halt));
      chk(e.id, "take_branch", 64'(take_branch),  64'(e.tb));
      chk(e.id, "instret",     64'(instret),      64'(e.cnt));
    end
  end

  task automatic push(input int id, input logic [63:0] pc, input logic [63:0] epc,
                      input logic tr, input logic hl, input logic tb, input logic [31:0] cnt);
    exp_t e;
    e.id = id; e.pc = pc; e.epc = epc; e.trap = tr; e.halt = hl; e.tb = tb; e.cnt = cnt;
    q.push_back(e);
  endtask

  // One clocked cycle with the given inputs; expected state is after the edge.
  task automatic step(input int id, input logic st, input logic br, input logic jmp,
                      input logic jr, input logic [2:0] f3, input logic z, input logic lt,
                      input logic ltu, input logic tr, input logic [63:0] imm,
                      input logic [63:0] rs1, input logic [63:0] e_pc, input logic [63:0] e_epc,
                      input logic e_trap, input logic e_halt, input logic [31:0] e_cnt,
                      input logic e_tb);
    stall = st; Branch = br; Jump = jmp; JumpReg = jr; funct3 = f3;
    Zero = z; LessThan = lt; LessThanU = ltu; trap_ret = tr;
    immediate = imm; rs1_data = rs1;
    @(posedge clk); #1;
    push(id, e_pc, e_epc, e_trap, e_halt, e_tb, e_cnt);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int id, input logic [63:0] e_pc, input logic [63:0] e_epc,
                      input logic e_trap, input logic e_halt, input logic [31:0] e_cnt);
    step(id, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 64'd0, 64'd0, e_pc, e_epc, e_trap, e_halt, e_cnt, 0);
  endtask

  task automatic do_reset(input int id);
    reset = 1'b1;
    stall = 0; Branch = 0; Jump = 0; JumpReg = 0; funct3 = 3'b000;
    Zero = 0; LessThan = 0; LessThanU = 0; trap_ret = 0;
    immediate = 64'd0; rs1_data = 64'd0;
    @(posedge clk); #1;
    push(id, 64'd0, 64'd0, 0, 0, 0, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    do_reset(0);

    // 1: three sequential cycles
    idle(1, 64'd4,  64'd0, 0, 0, 32'd1);
    idle(2, 64'd8,  64'd0, 0, 0, 32'd2);
    idle(3, 64'd12, 64'd0, 0, 0, 32'd3);

    // 2: branch conditions
    step(4, 0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 64'd32, 64'd0, 64'd44, 64'd0, 0, 0, 32'd4, 1); // BNE taken
    step(5, 0, 1, 0, 0, 3'b110, 0, 0, 0, 0, 64'd32, 64'd0, 64'd48, 64'd0, 0, 0, 32'd5, 0); // BLTU not taken
    step(6, 0, 1, 0, 0, 3'b100, 0, 1, 0, 0, 64'd8,  64'd0, 64'd56, 64'd0, 0, 0, 32'd6, 1); // BLT taken
    step(7, 0, 1, 0, 0, 3'b101, 0, 1, 0, 0, 64'd8,  64'd0, 64'd60, 64'd0, 0, 0, 32'd7, 0); // BGE not taken
    step(8, 0, 1, 0, 0, 3'b111, 0, 0, 0, 0, 64'd4,  64'd0, 64'd64, 64'd0, 0, 0, 32'd8, 1); // BGEU taken
    step(9, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 64'd40, 64'd0, 64'd68, 64'd0, 0, 0, 32'd9, 0); // BEQ not taken

    // 3: JALR beats JAL, low bit cleared; then stall with Jump held
    step(10, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0, 64'd4, 64'h101, 64'h104, 64'd0, 0, 0, 32'd10, 1);
    step(11, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 64'd6, 64'd0,   64'h104, 64'd0, 0, 0, 32'd10, 1);
    step(12, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0, 64'd6, 64'd0,   64'h104, 64'd0, 0, 0, 32'd10, 1);

    // 4: misaligned JAL traps, trap_ret (over a jump) returns to EPC+4
    step(13, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 64'd6, 64'd0, 64'h200, 64'h104, 1, 0, 32'd11, 1);
    idle(14, 64'h204, 64'h104, 1, 0, 32'd12);
    idle(15, 64'h208, 64'h104, 1, 0, 32'd13);
    step(16, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 64'd8, 64'd0, 64'h108, 64'h104, 0, 0, 32'd14, 1);
    // trap_ret ignored in RUN
    step(17, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 64'd0, 64'd0, 64'h10C, 64'h104, 0, 0, 32'd15, 0);

    // 5: trap again, then double fault halts
    step(18, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 64'd2, 64'd0, 64'h200, 64'h10C, 1, 0, 32'd16, 1);
    step(19, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 64'd2, 64'd0, 64'h200, 64'h10C, 0, 1, 32'd17, 1);
    for (int i = 0; i < 5; i++)
      step(20 + i, 0, 0, 1, 0, 3'b000, 0, 0, 0, 1, 64'd8, 64'd0, 64'h200, 64'h10C, 0, 1, 32'd17, 1);
    do_reset(25);

    // 6: backward branch wraps, 010 never taken, PC+4 wraps to 0
    step(26, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0,
         64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, 0, 32'd1, 1);
    step(27, 0, 1, 0, 0, 3'b010, 1, 1, 1, 0, 64'd8, 64'd0, 64'd0, 64'd0, 0, 0, 32'd2, 0);
    // JALR target with bit1 set after clearing bit0 traps
    step(28, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 64'd0, 64'd3, 64'h200, 64'd0, 1, 0, 32'd3, 1);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      n_tot++;
      $display("FAIL drain: %0d records left, required 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
